// File: rtl/mem_stage_dcache.sv
// ----------------------------------------------------------------------------
// mem_stage_dcache
// Memory stage of the MIPS pipeline. It has a direct-mapped, write-through,
// no-write-allocate data cache with one word per line. The cache sits in
// front of an internal backing RAM whose read latency is MISS_LAT cycles.
// A read miss stalls the pipeline while a two-state FSM (IDLE/FILL) refills
// the line. Branch resolution and the ALU-result passthrough are purely
// combinational.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   zero       in   ALU zero flag
//   branch     in   branch instruction
//   MemRead    in   load request
//   MemWrite   in   store request (wins when asserted together with MemRead)
//   aluRslt    in   byte address / ALU result
//   datafrmreg in   store data
//   hit        out  access hits a valid line (IDLE only)
//   stall      out  pipeline freeze request
//   pcSrc      out  branch taken
//   readdata   out  load data (0 unless a read hit)
//   aluRsltt   out  aluRslt passthrough
//   hit_cnt    out  saturating read-hit counter
//   miss_cnt   out  saturating read-miss counter
//
// LINES must be at least 2 and a power of two, and it must not exceed
// MEM_WORDS.
// ----------------------------------------------------------------------------
module mem_stage_dcache #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 256,
  parameter int LINES     = 16,
  parameter int MISS_LAT  = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              zero,
  input  logic              branch,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] aluRslt,
  input  logic [DATA_W-1:0] datafrmreg,
  output logic              hit,
  output logic              stall,
  output logic              pcSrc,
  output logic [DATA_W-1:0] readdata,
  output logic [ADDR_W-1:0] aluRsltt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int WA_W   = $clog2(MEM_WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = WA_W - IDX_W;
  // When the cache covers the whole RAM, the tag is empty. It is kept one
  // bit wide and held at zero so that the compare still works.
  localparam int TS_W   = (TAG_W > 0) ? TAG_W : 1;
  localparam int LAT_W  = $clog2(MISS_LAT + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
  logic [WA_W-1:0]        fill_addr_q, fill_addr_d;
  logic [LINES-1:0]       valid_q;
  logic [CNT_W-1:0]       hit_cnt_q, miss_cnt_q;
  logic [TS_W-1:0]        tag_q  [LINES];
  logic [DATA_W-1:0]      data_q [LINES];
  logic [DATA_W-1:0]      ram_q  [MEM_WORDS];

  logic [WA_W-1:0]        word_addr_s;
  logic [IDX_W-1:0]       idx_s;
  logic [TS_W-1:0]        tag_s;
  logic [IDX_W-1:0]       fill_idx_s;
  logic [TS_W-1:0]        fill_tag_s;
  logic                   lookup_s;
  logic                   rd_hit_s;
  logic                   rd_miss_s;
  logic                   wr_s;
  logic                   fill_now_s;
  logic                   unused_s;

  // Byte-offset bits and address bits above the RAM range are dropped, so
  // addresses wrap around the RAM.
  assign word_addr_s = aluRslt[2 +: WA_W];
  assign idx_s       = word_addr_s[IDX_W-1:0];
  assign tag_s       = TS_W'(word_addr_s >> IDX_W);
  assign fill_idx_s  = fill_addr_q[IDX_W-1:0];
  assign fill_tag_s  = TS_W'(fill_addr_q >> IDX_W);
  assign lookup_s    = valid_q[idx_s] & (tag_q[idx_s] == tag_s);
  assign unused_s    = ^{aluRslt[1:0], aluRslt[ADDR_W-1:WA_W+2]};

  assign pcSrc    = branch & zero;
  assign aluRsltt = aluRslt;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Next-state and output decode for the IDLE/FILL refill machine.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    fill_addr_d = fill_addr_q;
    hit         = 1'b0;
    stall       = 1'b0;
    readdata    = '0;
    rd_hit_s    = 1'b0;
    rd_miss_s   = 1'b0;
    wr_s        = 1'b0;
    fill_now_s  = 1'b0;
    case (state_q)
      IDLE: begin
        hit = lookup_s & (MemRead | MemWrite);
        if (MemRead && lookup_s) begin
          readdata = data_q[idx_s];
        end else begin
          readdata = '0;
        end
        // A simultaneous read and write is a write only.
        if (MemWrite) begin
          wr_s = 1'b1;
        end else if (MemRead && lookup_s) begin
          rd_hit_s = 1'b1;
        end else if (MemRead) begin
          rd_miss_s   = 1'b1;
          stall       = 1'b1;
          fill_addr_d = word_addr_s;
          lat_cnt_d   = LAT_W'(MISS_LAT - 1);
          state_d     = FILL;
        end else begin
          wr_s = 1'b0;
        end
      end
      FILL: begin
        stall = 1'b1;
        if (lat_cnt_q == '0) begin
          fill_now_s = 1'b1;
          state_d    = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM, latency counter, valid bits and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      fill_addr_q <= '0;
      valid_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      fill_addr_q <= fill_addr_d;
      if (fill_now_s) begin
        valid_q[fill_idx_s] <= 1'b1;
      end
      if (rd_hit_s && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
      if (rd_miss_s && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  // Storage arrays (RAM, tags, line data): not reset, but frozen while rst
  // is high so that reset beats any write or fill at the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_s) begin
        ram_q[word_addr_s] <= datafrmreg;
        if (lookup_s) begin
          data_q[idx_s] <= datafrmreg;
        end
      end
      if (fill_now_s) begin
        data_q[fill_idx_s] <= ram_q[fill_addr_q];
        tag_q[fill_idx_s]  <= fill_tag_s;
      end
    end
  end

endmodule
